// File: rtl/wb_arbiter.sv
// wb_arbiter: dual-port register-file writeback merging two ALU lanes and a buffered late-result stream.
// Optional WB_LATE_BYPASS_EN lets an accepted late result skip an empty FIFO straight to a free port.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu0_valid,
  input  logic [4:0]               alu0_rd,
  input  logic [XLEN-1:0]          alu0_data,
  input  logic                     alu1_valid,
  input  logic [4:0]               alu1_rd,
  input  logic [XLEN-1:0]          alu1_data,
  input  logic                     late_valid,
  output logic                     late_ready,
  input  logic [4:0]               late_rd,
  input  logic [XLEN-1:0]          late_data,
  output logic [4:0]               wr_addr0,
  output logic [XLEN-1:0]          wr_din0,
  output logic                     we0,
  output logic [4:0]               wr_addr1,
  output logic [XLEN-1:0]          wr_din1,
  output logic                     we1,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0]      rd_mem [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];
  logic [AW-1:0]   rptr, rptr1, wptr;
  logic [CW-1:0]   count;
  logic            a0, a1, h0_ok, h1_ok, h0_live, h1_live, pop0, pop1, push, push_fifo, byp_live;
  logic [1:0]      free, free_a, free_b, pops;
  logic [4:0]      cv;
  logic [4:0]      ca [5];
  logic [XLEN-1:0] cd [5];
  logic            p0v, p1v;
  logic [4:0]      p0a, p1a;
  logic [XLEN-1:0] p0d, p1d;
  function automatic logic hit(input logic [4:0] rd);
    return (alu0_valid && alu0_rd == rd) || (alu1_valid && alu1_rd == rd);
  endfunction
  assign fifo_count = count;
  assign late_ready = count != CW'(DEPTH);
  assign rptr1      = rptr + AW'(1);
  always_comb begin
    a0 = alu0_valid && alu0_rd != 5'd0 && !(alu1_valid && alu1_rd == alu0_rd);
    a1 = alu1_valid && alu1_rd != 5'd0;
    h0_ok = count != '0;
    h1_ok = count > CW'(1);
    h0_live = h0_ok && rd_mem[rptr] != 5'd0 && !hit(rd_mem[rptr]);
    h1_live = h1_ok && rd_mem[rptr1] != 5'd0 && !hit(rd_mem[rptr1]);
    free = 2'd2 - {1'b0, a0} - {1'b0, a1};
    // Dead heads (x0 or overwritten by a younger ALU result) pop without needing a port
    pop0 = h0_ok && (!h0_live || free != 2'd0);
    free_a = free - {1'b0, pop0 && h0_live};
    pop1 = pop0 && h1_ok && (!h1_live || free_a != 2'd0);
    free_b = free_a - {1'b0, pop1 && h1_live};
    pops = {1'b0, pop0} + {1'b0, pop1};
    push = late_valid && late_ready;
`ifdef WB_LATE_BYPASS_EN
    push_fifo = push && !(count == CW'(pops) && free_b != 2'd0);
    byp_live = push && !push_fifo && late_rd != 5'd0 && !hit(late_rd);
`else
    push_fifo = push;
    byp_live = 1'b0;
`endif
    cv = {byp_live, pop1 && h1_live, pop0 && h0_live, a1, a0};
    ca[0] = alu0_rd;        cd[0] = alu0_data;
    ca[1] = alu1_rd;        cd[1] = alu1_data;
    ca[2] = rd_mem[rptr];   cd[2] = data_mem[rptr];
    ca[3] = rd_mem[rptr1];  cd[3] = data_mem[rptr1];
    ca[4] = late_rd;        cd[4] = late_data;
    p0v = 1'b0; p0a = '0; p0d = '0;
    p1v = 1'b0; p1a = '0; p1d = '0;
    for (int i = 0; i < 5; i++) begin
      if (cv[i] && !p0v) begin
        p0v = 1'b1; p0a = ca[i]; p0d = cd[i];
      end else if (cv[i] && !p1v) begin
        p1v = 1'b1; p1a = ca[i]; p1d = cd[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push_fifo) begin
      rd_mem[wptr]   <= late_rd;
      data_mem[wptr] <= late_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we0      <= 1'b0;
      we1      <= 1'b0;
      wr_addr0 <= '0;
      wr_addr1 <= '0;
      wr_din0  <= '0;
      wr_din1  <= '0;
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
    end else begin
      we0 <= p0v;
      we1 <= p1v;
      if (p0v) begin
        wr_addr0 <= p0a;
        wr_din0  <= p0d;
      end
      if (p1v) begin
        wr_addr1 <= p1a;
        wr_din1  <= p1d;
      end
      rptr  <= rptr + AW'(pops);
      wptr  <= wptr + AW'(push_fifo);
      count <= count + CW'(push_fifo) - CW'(pops);
    end
  end
endmodule
